dat_mem_stk: RTL and testbench
==============================

// Module: dat_mem_stk
// PURPOSE
//  Parametrised data memory with a hardware stack port. One array serves two access
//  kinds: ordinary load/store at an explicit address, and push/pop against a
//  descending stack region with occupancy tracking and sticky overflow/underflow flags.
//  Sits beside the register file; the controller issues one mem_op per cycle.
// PARAMETERS
//  DW        8    data word width (bits)
//  AW        8    address width; array depth = 2**AW words
//  SP_INIT   255  address of the first (bottom) stack slot; stack grows toward 0
//  STK_DEPTH 32   max stack entries; legal range 1..SP_INIT+1
// PORTS
//  clk       in   1         rising-edge clock
//  rst_n     in   1         asynchronous, active-low reset
//  mem_op    in   3         dat_mem_pkg::mem_op_t: NOP, LOAD, STORE, PUSH, POP
//  addr      in   AW        load/store address (ignored for NOP/PUSH/POP)
//  dat_in    in   DW        store/push data
//  err_clr   in   1         clears sticky error flags
//  dat_out   out  DW        combinational read data
//  top       out  DW        current top-of-stack word (undefined when empty)
//  count     out  $clog2(STK_DEPTH+1)  stack occupancy
//  empty     out  1         count == 0
//  full      out  1         count == STK_DEPTH
//  err_ovf   out  1         sticky: PUSH attempted while full
//  err_udf   out  1         sticky: POP attempted while empty
// BEHAVIOUR
//  - Reset (rst_n low, async): count=0, empty=1, full=0, err_ovf=0, err_udf=0. Array
//    contents are not reset. No write occurs on any edge while rst_n is low.
//  - Stack slot addressing: push slot = SP_INIT-count; top slot = SP_INIT-count+1.
//    All address arithmetic is in AW bits, with no wrap beyond the STK_DEPTH limit.
//  - dat_out is combinational, with zero latency:
//    LOAD -> core[addr]; POP -> core[top slot]; otherwise -> core[addr].
//  - top = core[SP_INIT-count+1], combinational, and tracks each write on the next cycle.
//  - STORE: core[addr] <= dat_in at posedge. count is unchanged.
//  - PUSH when !full: core[SP_INIT-count] <= dat_in and count+1 at the same edge.
//  - PUSH when full: no write, count holds, err_ovf <= 1.
//  - POP when !empty: dat_out presents the top word during the cycle; count-1 at the edge.
//  - POP when empty: dat_out = core[SP_INIT+1 mod 2**AW] (don't-care), count holds,
//    err_udf <= 1.
//  - NOP/LOAD: no state change.
//  - The one-op-per-cycle encoding excludes simultaneous push/pop.
//  - err_clr clears both flags at the edge. A new error in the same cycle wins (flag = 1).
//  - A STORE into the stack region is permitted and unchecked; it silently alters
//    stacked data.
//  - Undefined mem_op encodings behave as NOP.
//  - Reset mid-sequence discards occupancy: after release, the stack is empty
//    regardless of prior pushes.
// STRUCTURE
//  - dat_mem_pkg: mem_op_t enum (NOP=0, LOAD=1, STORE=2, PUSH=3, POP=4) and the
//    default DW/AW constants.
//  - Sub-module dat_mem_core: a DW x 2**AW array with one combinational read port
//    (a second read port for top), one clocked write port, and no reset.
//  - The top level holds the count register, flag registers, op decode, write-enable
//    gating and address muxing.
// TESTING
//  1 reset: rst_n=0 for 2 cycles then release -> count=0, empty=1, full=0, errs=0.
//  2 STORE addr=0x10 dat_in=0xA5, then LOAD 0x10 -> dat_out=0xA5 in the LOAD cycle.
//  3 PUSH 0x11, 0x22, 0x33 -> count=3, top=0x33, core[255]=0x11;
//    POP x3 -> dat_out 0x33, 0x22, 0x11, then empty=1.
//  4 32 PUSHes -> full=1; 33rd PUSH 0xEE -> count=32, err_ovf=1, core[223] unchanged;
//    err_clr -> err_ovf=0.
//  5 POP on empty -> err_udf=1, count=0; POP with err_clr in the same cycle -> err_udf
//    stays 1.
//  6 PUSH 0x44 x2, assert rst_n=0 mid-cycle with PUSH pending -> count=0 immediately,
//    no write at the masked edge, empty=1 after release.

Source files
------------

// File: rtl/dat_mem_pkg.sv
// Shared op encoding and default sizing for the data memory / stack block.
package dat_mem_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 8;
  localparam int unsigned OP_W   = 3;

  // One memory operation per cycle; unlisted encodings decode as NOP.
  typedef enum logic [OP_W-1:0] {
    NOP   = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    PUSH  = 3'd3,
    POP   = 3'd4
  } mem_op_t;

endpackage

// File: rtl/dat_mem_core.sv
// DW x 2**AW storage array: two combinational read ports, one clocked write port, no reset.
module dat_mem_core #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  input  logic [AW-1:0] i_taddr,
  output logic [DW-1:0] o_tdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Single write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_tdata = r_mem[i_taddr];

endmodule

// File: rtl/dat_mem_stk.sv
// Data memory with a descending hardware stack: op decode, occupancy and sticky error flags.
module dat_mem_stk
  import dat_mem_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned SP_INIT   = 255,
  parameter int unsigned STK_DEPTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [OP_W-1:0]                mem_op,
  input  logic [AW-1:0]                  addr,
  input  logic [DW-1:0]                  dat_in,
  input  logic                           err_clr,
  output logic [DW-1:0]                  dat_out,
  output logic [DW-1:0]                  top,
  output logic [$clog2(STK_DEPTH+1)-1:0] count,
  output logic                           empty,
  output logic                           full,
  output logic                           err_ovf,
  output logic                           err_udf
);

  localparam int unsigned CW = $clog2(STK_DEPTH + 1);

  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_err_ovf;
  logic          r_err_udf;

  mem_op_t       w_op;
  logic          w_is_store;
  logic          w_is_push;
  logic          w_is_pop;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_we;
  logic [AW-1:0] w_push_addr;
  logic [AW-1:0] w_top_addr;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;
  logic [CW-1:0] w_count_nxt;
  logic [DW-1:0] w_rdata;
  logic [DW-1:0] w_tdata;

  assign w_op       = mem_op_t'(mem_op);
  assign w_is_store = (w_op == STORE);
  assign w_is_push  = (w_op == PUSH);
  assign w_is_pop   = (w_op == POP);
  assign w_push_ok  = w_is_push && !r_full;
  assign w_pop_ok   = w_is_pop && !r_empty;

  // Stack slots grow downward from SP_INIT; top sits one slot above the push slot.
  assign w_push_addr = AW'(SP_INIT) - AW'(r_count);
  assign w_top_addr  = w_push_addr + AW'(1);

  // Write enable is masked while reset is held so no edge during reset commits data.
  assign w_we    = (w_is_store || w_push_ok) && rst_n;
  assign w_waddr = w_is_push ? w_push_addr : addr;
  assign w_raddr = w_is_pop ? w_top_addr : addr;

  // Next occupancy; a rejected push/pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop_ok) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Occupancy with registered empty/full derived from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(STK_DEPTH));
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_is_push && r_full) begin
        r_err_ovf <= 1'b1;
      end else if (err_clr) begin
        r_err_ovf <= 1'b0;
      end
      if (w_is_pop && r_empty) begin
        r_err_udf <= 1'b1;
      end else if (err_clr) begin
        r_err_udf <= 1'b0;
      end
    end
  end

  dat_mem_core #(
    .DW (DW),
    .AW (AW)
  ) u_core (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (dat_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata),
    .i_taddr (w_top_addr),
    .o_tdata (w_tdata)
  );

  assign dat_out = w_rdata;
  assign top     = w_tdata;
  assign count   = r_count;
  assign empty   = r_empty;
  assign full    = r_full;
  assign err_ovf = r_err_ovf;
  assign err_udf = r_err_udf;

endmodule

// File: tb/tb_dat_mem_stk.sv
// Directed bench for dat_mem_stk: load/store, push/pop, overflow/underflow, reset mid-sequence.
module tb_dat_mem_stk;
  import dat_mem_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] mem_op;
  logic [7:0] addr;
  logic [7:0] dat_in;
  logic       err_clr;
  logic [7:0] dat_out;
  logic [7:0] top;
  logic [5:0] count;
  logic       empty;
  logic       full;
  logic       err_ovf;
  logic       err_udf;

  int n_checks = 0;
  int n_fails  = 0;

  dat_mem_stk #(
    .DW        (8),
    .AW        (8),
    .SP_INIT   (255),
    .STK_DEPTH (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_op  (mem_op),
    .addr    (addr),
    .dat_in  (dat_in),
    .err_clr (err_clr),
    .dat_out (dat_out),
    .top     (top),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .err_ovf (err_ovf),
    .err_udf (err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op at the falling edge and let it settle; caller checks then clocks it.
  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic clr);
    @(negedge clk);
    mem_op  = op;
    addr    = a;
    dat_in  = d;
    err_clr = clr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    mem_op  = 3'(NOP);
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (count !== 6'd0) begin n_fails++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++;
    if (full !== 1'b0) begin n_fails++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++;
    if ({err_ovf, err_udf} !== 2'b00) begin
      n_fails++; $display("FAIL reset_errs got %b%b want 00", err_ovf, err_udf);
    end
  endtask

  task automatic test_load_store;
    drive(3'(STORE), 8'h10, 8'hA5, 1'b0);
    tick();
    drive(3'(LOAD), 8'h10, 8'h00, 1'b0);
    n_checks++;
    if (dat_out !== 8'hA5) begin n_fails++; $display("FAIL load_10 got %h want a5", dat_out); end
    tick();
    n_checks++;
    if (count !== 6'd0) begin n_fails++; $display("FAIL store_count got %0d want 0", count); end
  endtask

  task automatic test_push_pop;
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(3'(PUSH), 8'h00, vals[i], 1'b0);
      tick();
    end
    n_checks++;
    if (count !== 6'd3) begin n_fails++; $display("FAIL push3_count got %0d want 3", count); end
    n_checks++;
    if (top !== 8'h33) begin n_fails++; $display("FAIL push3_top got %h want 33", top); end
    drive(3'(LOAD), 8'hFF, 8'h00, 1'b0);
    n_checks++;
    if (dat_out !== 8'h11) begin n_fails++; $display("FAIL core255 got %h want 11", dat_out); end
    tick();
    for (int i = 2; i >= 0; i--) begin
      drive(3'(POP), 8'h00, 8'h00, 1'b0);
      n_checks++;
      if (dat_out !== vals[i]) begin
        n_fails++; $display("FAIL pop3_%0d got %h want %h", i, dat_out, vals[i]);
      end
      tick();
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 6'd0) begin
      n_fails++; $display("FAIL pop3_empty got empty=%b count=%0d want 1/0", empty, count);
    end
  endtask

  task automatic test_overflow;
    drive(3'(STORE), 8'hDF, 8'h5A, 1'b0);
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(3'(PUSH), 8'h00, 8'(8'h80 + i), 1'b0);
      tick();
    end
    n_checks++;
    if (full !== 1'b1 || count !== 6'd32) begin
      n_fails++; $display("FAIL full got full=%b count=%0d want 1/32", full, count);
    end
    n_checks++;
    if (top !== 8'h9F) begin n_fails++; $display("FAIL full_top got %h want 9f", top); end
    drive(3'(PUSH), 8'h00, 8'hEE, 1'b0);
    tick();
    n_checks++;
    if (err_ovf !== 1'b1 || count !== 6'd32) begin
      n_fails++; $display("FAIL ovf got err_ovf=%b count=%0d want 1/32", err_ovf, count);
    end
    drive(3'(LOAD), 8'hDF, 8'h00, 1'b0);
    n_checks++;
    if (dat_out !== 8'h5A) begin n_fails++; $display("FAIL core223 got %h want 5a", dat_out); end
    tick();
    drive(3'(NOP), 8'h00, 8'h00, 1'b1);
    tick();
    n_checks++;
    if (err_ovf !== 1'b0) begin n_fails++; $display("FAIL ovf_clr got %b want 0", err_ovf); end
    for (int i = 31; i >= 0; i--) begin
      drive(3'(POP), 8'h00, 8'h00, 1'b0);
      n_checks++;
      if (dat_out !== 8'(8'h80 + i)) begin
        n_fails++; $display("FAIL pop32_%0d got %h want %h", i, dat_out, 8'(8'h80 + i));
      end
      tick();
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL pop32_empty got %b want 1", empty); end
  endtask

  task automatic test_underflow;
    drive(3'(POP), 8'h00, 8'h00, 1'b0);
    tick();
    n_checks++;
    if (err_udf !== 1'b1 || count !== 6'd0) begin
      n_fails++; $display("FAIL udf got err_udf=%b count=%0d want 1/0", err_udf, count);
    end
    drive(3'(NOP), 8'h00, 8'h00, 1'b1);
    tick();
    n_checks++;
    if (err_udf !== 1'b0) begin n_fails++; $display("FAIL udf_clr got %b want 0", err_udf); end
    drive(3'(POP), 8'h00, 8'h00, 1'b1);
    tick();
    n_checks++;
    if (err_udf !== 1'b1) begin n_fails++; $display("FAIL udf_win got %b want 1", err_udf); end
    n_checks++;
    if (err_ovf !== 1'b0) begin n_fails++; $display("FAIL udf_ovf got %b want 0", err_ovf); end
    drive(3'(NOP), 8'h00, 8'h00, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2; i++) begin
      drive(3'(PUSH), 8'h00, 8'h44, 1'b0);
      tick();
    end
    n_checks++;
    if (count !== 6'd2) begin n_fails++; $display("FAIL mid_pre got %0d want 2", count); end
    drive(3'(PUSH), 8'h00, 8'h77, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 6'd0 || empty !== 1'b1) begin
      n_fails++; $display("FAIL mid_async got count=%0d empty=%b want 0/1", count, empty);
    end
    @(posedge clk);
    #1;
    mem_op = 3'(NOP);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (empty !== 1'b1 || count !== 6'd0) begin
      n_fails++; $display("FAIL mid_release got empty=%b count=%0d want 1/0", empty, count);
    end
    drive(3'(LOAD), 8'hFD, 8'h00, 1'b0);
    n_checks++;
    if (dat_out !== 8'h82) begin n_fails++; $display("FAIL mid_nowrite got %h want 82", dat_out); end
    tick();
  endtask

  initial begin
    mem_op  = 3'(NOP);
    addr    = 8'h00;
    dat_in  = 8'h00;
    err_clr = 1'b0;
    rst_n   = 1'b1;
    test_reset();
    test_load_store();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
